oh_rrmux: RTL and testbench

Parametrised N-channel round-robin arbitrating multiplexer with a registered output and valid/ready handshake on every port. It generalises the one-hot select mux: the select is generated internally by a fair arbiter rather than supplied by the caller, and the result is held in an output register until the consumer accepts it. It sits at merge points in the fabric where several producers share one downstream channel, such as transaction merge, emesh ports and DMA read-return joins.

---
 rtl/oh_rrmux.sv | 109 ++++++++++
 tb/tb_oh_rrmux.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/oh_rrmux.sv
// oh_rrmux: N-channel round-robin arbitrating mux with a registered output.
// Several producers share one downstream channel. A fair arbiter picks one
// valid input per cycle. The winning word is held in an output register until
// the consumer accepts it.
//
// Optional build macro: OH_RRMUX_FIXED_EN. When it is defined, the lowest-index
// valid channel always wins and the rotating pointer is removed.
//
// Handshake: every port uses valid/ready. A word moves on a rising edge only
// when valid and ready are both high in that cycle. in_ready is the one-hot
// grant gated by load (~out_valid | out_ready), so it depends combinationally
// on in_valid and out_ready. Producers must keep in_valid independent of
// in_ready.
module oh_rrmux #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [N-1:0]    out_sel,
  input  logic            out_ready
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic          load;
  logic          xfer;
  logic [N-1:0]  grant;
  logic [DW-1:0] win_data;
  logic          found;

`ifdef OH_RRMUX_FIXED_EN
  // Fixed priority: the first valid channel, counting up from 0, wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && in_valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  int            idx;

  // Round-robin search. It starts at ptr, moves upward and wraps from N-1
  // to 0. The first valid channel wins. ptr_nxt points one past the winner.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    ptr_nxt = ptr;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && in_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_nxt    = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // The pointer moves only on a transfer. Idle cycles and stalls leave it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)   ptr <= '0;
    else if (xfer) ptr <= ptr_nxt;
  end
`endif

  // AND-OR mux of the granted channel. An all-zero grant gives zero data.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      win_data = win_data | (in_data[i*DW +: DW] & {DW{grant[i]}});
    end
  end

  // in_ready is held low while reset is asserted so that no producer sees an
  // accept the register cannot honour.
  assign load     = ~out_valid | out_ready;
  assign in_ready = grant & {N{load & nreset}};
  assign xfer     = |in_ready;

  // Output register. A transfer loads a new word; a drain with nothing
  // pending empties the register; a stall holds the word.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_sel   <= grant;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oh_rrmux.sv
// tb_oh_rrmux: directed and random stimulus for oh_rrmux with N=4, DW=8.
// Expected words go into a queue when a transfer is driven. They are popped
// and compared when the output register drains.
module tb_oh_rrmux;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            nreset;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [N-1:0]    out_sel;
  logic            out_ready;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic            m_valid = 1'b0;
  int              m_ptr   = 0;
  logic [N+DW-1:0] exp_q[$];

  oh_rrmux #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference arbiter: search upward from the start channel and wrap.
  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (start + k) % N;
      if (v[c]) return N'(1) << c;
    end
    return '0;
  endfunction

  // Drive one cycle. Inputs are applied just after a rising edge. The DUT is
  // checked at the falling edge, and then the model advances.
  task automatic step(input logic [N-1:0] v, input logic rdy, input logic [N*DW-1:0] d);
    logic            load;
    logic [N-1:0]    g;
    logic [N-1:0]    exp_rdy;
    logic [N+DW-1:0] w;
    int              start;
    int              win;
    in_valid  = v;
    out_ready = rdy;
    in_data   = d;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q[0];
        chk("out_data", 32'(out_data), 32'(w[DW-1:0]));
        chk("out_sel", 32'(out_sel), 32'(w[N+DW-1:DW]));
      end
    end
`ifdef OH_RRMUX_FIXED_EN
    start = 0;
`else
    start = m_ptr;
`endif
    load    = !m_valid || rdy;
    g       = model_grant(v, start);
    exp_rdy = load ? g : '0;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (m_valid && rdy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (|exp_rdy) begin
      win = 0;
      for (int i = 0; i < N; i++) if (g[i]) win = i;
      exp_q.push_back({g, d[win*DW +: DW]});
      m_ptr   = (win + 1) % N;
      m_valid = 1'b1;
    end else if (load) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = 0;
    exp_q.delete();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_out_sel"},   32'(out_sel),   32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
  endtask

  initial begin
    logic [N*DW-1:0] sweep;
    sweep = 32'h3322_1100;

    // reset held with every input active
    nreset    = 1'b0;
    in_valid  = 4'b1111;
    in_data   = sweep;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk);
    #1;
    nreset = 1'b1;

    // round-robin sweep: 00,11,22,33,00
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, sweep);

    // fairness skip: only ch1 and ch3 request
    for (int i = 0; i < 5; i++) step(4'b1010, 1'b1, 32'hA3B2_C1D0);

    // backpressure for five cycles, then release
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, sweep);
    step(4'b1111, 1'b1, 32'h4433_2211);

    // drain, then idle bubble with a single ch2 transfer
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, '0);
    step(4'b0100, 1'b1, 32'h00EE_0000);
    step(4'b0000, 1'b1, '0);
    step(4'b0000, 1'b1, '0);
    step(4'b0001, 1'b1, 32'h0000_005A);
    step(4'b0000, 1'b1, '0);

    // random traffic
    for (int i = 0; i < 60; i++)
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), 32'($urandom));

    // reset while a word is held under a stall
    step(4'b1111, 1'b1, sweep);
    step(4'b1111, 1'b0, sweep);
    nreset = 1'b0;
    #1;
    chk_reset_state("midreset");
    model_reset();
    @(posedge clk);
    #1;
    nreset = 1'b1;
    step(4'b0110, 1'b1, 32'h0077_6600);
    step(4'b0000, 1'b1, '0);
    step(4'b0000, 1'b1, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
